seq_mult_display: RTL and testbench

Parametrised sequential unsigned multiplier with an integrated binary-to-BCD converter and a 4-digit multiplexed seven-segment driver. It is the next generation of the lab's 4x4 combinational multiplier/display top: operand width is a parameter, multiplication is shift-add over several cycles with a start/busy/done handshake, and the result is shown in decimal with leading-zero blanking. It sits directly under the board top, between the switch inputs and the Basys-style common-anode display.

---
 rtl/seq_mult_display.sv | 168 ++++++++++++++++
 tb/tb_seq_mult_display.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_display.sv
// Sequential shift-add unsigned multiplier with double-dabble BCD conversion
// and a 4-digit multiplexed common-anode seven-segment driver.
module seq_mult_display #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [3:0]         seg_anode,
  output logic [6:0]         seg_cathode
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] MULT_LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BCD_LAST     = CW'(PW - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, MULT, BCD, DONE} state_t;

  state_t            state, state_next;
  logic              accept;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     mcand, acc, acc_next, shreg;
  logic [WIDTH-1:0]  mplier;
  logic [15:0]       bcd, bcd_adj, bcd_next;
  logic [3:0][3:0]   digits;
  logic [RW-1:0]     refresh_cnt;
  logic [1:0]        digit_idx;
  logic [3:0]        cur_digit;
  logic              blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; otherwise an
    // uncovered path would hold its old value and infer a latch.
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = MULT;
        accept     = 1'b1;
      end
      MULT:    if (cnt == MULT_LAST) state_next = BCD;
      BCD:     if (cnt == BCD_LAST)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // --------------------------------------------------------------- datapath
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                  : bcd[4*i +: 4];
    end
    bcd_next = (bcd_adj << 1) | 16'(shreg[PW-1]);
  end

  // NOTE: working registers are reset along with the visible ones so that an
  // aborted operation leaves no stale partial product behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      shreg   <= '0;
      bcd     <= '0;
      product <= '0;
      digits  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mcand  <= PW'(a);
          mplier <= b;
          acc    <= '0;
          cnt    <= '0;
        end
        MULT: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == MULT_LAST) begin
            // Final partial sum goes straight into the BCD shifter.
            cnt   <= '0;
            shreg <= acc_next;
            bcd   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BCD: begin
          bcd   <= bcd_next;
          shreg <= shreg << 1;
          cnt   <= cnt + CW'(1);
          if (cnt == BCD_LAST) begin
            product <= acc;
            digits  <= bcd_next;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Anode and cathode decode from the same registers, so both switch together.
  always_comb begin
    cur_digit = digits[digit_idx];
    blank     = 1'b0;
    case (digit_idx)
      2'd3:    blank = (digits[3]   == 4'd0);
      2'd2:    blank = (digits[3:2] == 8'd0);
      2'd1:    blank = (digits[3:1] == 12'd0);
      default: blank = 1'b0;
    endcase
    seg_anode   = ~(4'b0001 << digit_idx);
    seg_cathode = blank ? 7'b1111111 : seg_decode(cur_digit);
  end

endmodule

// File: tb/tb_seq_mult_display.sv
// Scoreboard bench for seq_mult_display: one WIDTH=4 and one WIDTH=6 instance,
// both with REFRESH_DIV=4, checked against an arithmetic reference model.
module tb_seq_mult_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start6;
  logic [3:0] a4, b4;
  logic [5:0] a6, b6;
  logic       busy4, done4, busy6, done6;
  logic [7:0] prod4;
  logic [11:0] prod6;
  logic [3:0] an4, an6;
  logic [6:0] cat4, cat6;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_disp  = 0;
  int exp4[$], exp6[$];
  int done_cyc4[$];
  int acc_cyc4 = 0, acc_cyc6 = 0;
  logic busy4_d = 1'b0, busy6_d = 1'b0;
  int pe4, pe6;

  always #5 clk = ~clk;

  seq_mult_display #(.WIDTH(4), .REFRESH_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4),
    .seg_anode(an4), .seg_cathode(cat4)
  );

  seq_mult_display #(.WIDTH(6), .REFRESH_DIV(4)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .a(a6), .b(b6),
    .busy(busy6), .done(done6), .product(prod6),
    .seg_anode(an6), .seg_cathode(cat6)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Clock edges since reset release; the scanned digit is (t / 4) mod 4.
  always @(posedge clk or posedge rst) begin
    if (rst) t_disp <= 0;
    else     t_disp <= t_disp + 1;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int exp_seg(input int v, input int idx);
    int p;
    int d;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && v < p) return 7'b1111111;
    d = (v / p) % 10;
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Monitors: pop the expected product whenever a done pulse appears.
  always @(negedge clk) begin
    if (rst) begin
      busy4_d = 1'b0;
    end else begin
      if (busy4 && !busy4_d) acc_cyc4 = cyc;
      if (done4) begin
        done_cyc4.push_back(cyc);
        if (exp4.size() == 0) begin
          check("w4 unexpected done", 1, 0);
        end else begin
          pe4 = exp4.pop_front();
          check("w4 product", int'(prod4), pe4);
          check("w4 latency", cyc - acc_cyc4 + 1, 13);
        end
      end
      busy4_d = busy4;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      busy6_d = 1'b0;
    end else begin
      if (busy6 && !busy6_d) acc_cyc6 = cyc;
      if (done6) begin
        if (exp6.size() == 0) begin
          check("w6 unexpected done", 1, 0);
        end else begin
          pe6 = exp6.pop_front();
          check("w6 product", int'(prod6), pe6);
          check("w6 latency", cyc - acc_cyc6 + 1, 19);
        end
      end
      busy6_d = busy6;
    end
  end

  task automatic wait_idle(input int w);
    for (int i = 0; i < 100; i++) begin
      if (((w == 4) ? busy4 : busy6) == 1'b0) break;
      @(negedge clk);
    end
    check($sformatf("w%0d idle", w), int'((w == 4) ? busy4 : busy6), 0);
  endtask

  task automatic op(input int w, input int av, input int bv);
    wait_idle(w);
    if (w == 4) begin
      a4 = 4'(av); b4 = 4'(bv); start4 = 1'b1; exp4.push_back(av * bv);
    end else begin
      a6 = 6'(av); b6 = 6'(bv); start6 = 1'b1; exp6.push_back(av * bv);
    end
    @(negedge clk);
    start4 = 1'b0;
    start6 = 1'b0;
    wait_idle(w);
  endtask

  // Scan a full refresh round and compare every anode/cathode sample.
  task automatic check_disp(input int w, input int v);
    int idx;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idx = (t_disp / 4) % 4;
      check($sformatf("w%0d anode", w), int'((w == 4) ? an4 : an6), (~(1 << idx)) & 15);
      check($sformatf("w%0d cathode d%0d v%0d", w, idx, v),
            int'((w == 4) ? cat4 : cat6), exp_seg(v, idx));
    end
  endtask

  initial begin
    int av, bv;
    bit seen;
    rst = 1'b1; start4 = 1'b0; start6 = 1'b0;
    a4 = '0; b4 = '0; a6 = '0; b6 = '0;
    #2;
    check("rst busy4", int'(busy4), 0);
    check("rst done4", int'(done4), 0);
    check("rst prod4", int'(prod4), 0);
    check("rst anode4", int'(an4), 4'b1110);
    check("rst cathode4", int'(cat4), 7'b1000000);
    check("rst prod6", int'(prod6), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=4 results, each followed by a display scan.
    op(4, 1, 3);   check_disp(4, 3);
    op(4, 9, 11);  check_disp(4, 99);
    op(4, 4, 5);   check_disp(4, 20);
    op(4, 7, 3);   check_disp(4, 21);
    op(4, 15, 15); check_disp(4, 225);
    op(4, 0, 9);   check_disp(4, 0);

    // start re-asserted mid-operation with new operands is ignored.
    wait_idle(4);
    a4 = 4'd2; b4 = 4'd3; start4 = 1'b1; exp4.push_back(6);
    @(negedge clk); start4 = 1'b0;
    repeat (3) @(negedge clk);
    a4 = 4'd5; b4 = 4'd5; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    wait_idle(4);
    check("w4 ignored start product", int'(prod4), 6);
    check_disp(4, 6);

    // start held high: two back-to-back operations 14 cycles apart.
    done_cyc4.delete();
    a4 = 4'd3; b4 = 4'd4; start4 = 1'b1; exp4.push_back(12);
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd6; exp4.push_back(30);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4) begin seen = 1'b1; break; end
    end
    check("w4 first b2b done seen", int'(seen), 1);
    repeat (2) @(negedge clk);
    start4 = 1'b0;
    wait_idle(4);
    check("w4 b2b done count", done_cyc4.size(), 2);
    if (done_cyc4.size() == 2)
      check("w4 b2b spacing", done_cyc4[1] - done_cyc4[0], 14);

    // Reset in the middle of MULT aborts with no done and clears the display.
    done_cyc4.delete();
    wait_idle(4);
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (2) @(negedge clk);
    check("w4 busy before abort", int'(busy4), 1);
    rst = 1'b1;
    #1;
    check("abort busy4", int'(busy4), 0);
    check("abort done4", int'(done4), 0);
    check("abort prod4", int'(prod4), 0);
    check("abort prod6", int'(prod6), 0);
    check("abort anode4", int'(an4), 4'b1110);
    check("abort cathode4", int'(cat4), 7'b1000000);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort no done pulse", done_cyc4.size(), 0);
    check_disp(4, 0);

    // WIDTH=6 extremes and full scan.
    op(6, 63, 63); check_disp(6, 3969);
    op(6, 1, 1);   check_disp(6, 1);
    op(6, 40, 25); check_disp(6, 1000);

    // Randomized operands on both widths.
    for (int n = 0; n < 15; n++) begin
      av = $urandom_range(0, 15); bv = $urandom_range(0, 15);
      op(4, av, bv);
      check_disp(4, av * bv);
      av = $urandom_range(0, 63); bv = $urandom_range(0, 63);
      op(6, av, bv);
      check_disp(6, av * bv);
    end

    repeat (4) @(negedge clk);
    check("w4 scoreboard drained", exp4.size(), 0);
    check("w6 scoreboard drained", exp6.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
